gd_mem_arbiter: RTL and testbench



---
 rtl/gd_mem_arbiter.sv | 136 +++++++++++++
 tb/tb_gd_mem_arbiter.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gd_mem_arbiter.sv
// gd_mem_arbiter: shares one single-port video RAM between the
// unstallable SPI host path and a stallable engine requester.
module gd_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              h_re,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_raddr,
  input  logic [ADDR_W-1:0] h_waddr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic [DATA_W-1:0] h_rdata,
  output logic              h_overrun,
  input  logic              e_req,
  input  logic              e_we,
  input  logic [ADDR_W-1:0] e_addr,
  input  logic [DATA_W-1:0] e_wdata,
  output logic              e_gnt,
  output logic              e_rvalid,
  output logic [DATA_W-1:0] e_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_HOST,
    OWN_ENG
  } owner_e;

  logic              h_re_q;
  logic              h_we_q;
  logic              rd_pend;
  logic              wr_pend;
  logic [ADDR_W-1:0] rd_buf;
  logic [ADDR_W-1:0] wr_buf;
  logic [DATA_W-1:0] wr_dbuf;
  owner_e            rd_owner;
  owner_e            owner_nxt;
  logic [DATA_W-1:0] h_rdata_q;
  logic [DATA_W-1:0] e_rdata_q;
  logic              ovr_q;

  logic rd_rise;
  logic wr_rise;
  logic rd_issue;
  logic wr_issue;

  assign rd_rise = h_re & ~h_re_q;
  assign wr_rise = h_we & ~h_we_q;

  // Fixed priority: host write, host read, then engine.
  // Engine path is gated so nothing issues while reset is held.
  always_comb begin
    m_en      = 1'b0;
    m_we      = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    e_gnt     = 1'b0;
    rd_issue  = 1'b0;
    wr_issue  = 1'b0;
    owner_nxt = OWN_NONE;
    priority case (1'b1)
      wr_pend: begin
        m_en     = 1'b1;
        m_we     = 1'b1;
        m_addr   = wr_buf;
        m_wdata  = wr_dbuf;
        wr_issue = 1'b1;
      end
      rd_pend: begin
        m_en      = 1'b1;
        m_addr    = rd_buf;
        rd_issue  = 1'b1;
        owner_nxt = OWN_HOST;
      end
      (e_req & rst_n): begin
        m_en    = 1'b1;
        m_we    = e_we;
        m_addr  = e_addr;
        m_wdata = e_wdata;
        e_gnt   = 1'b1;
        if (!e_we) owner_nxt = OWN_ENG;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_re_q    <= 1'b0;
      h_we_q    <= 1'b0;
      rd_pend   <= 1'b0;
      wr_pend   <= 1'b0;
      rd_buf    <= '0;
      wr_buf    <= '0;
      wr_dbuf   <= '0;
      rd_owner  <= OWN_NONE;
      h_rdata_q <= '0;
      e_rdata_q <= '0;
      ovr_q     <= 1'b0;
    end else begin
      h_re_q   <= h_re;
      h_we_q   <= h_we;
      rd_owner <= owner_nxt;
      if (rd_issue) rd_pend <= 1'b0;
      if (wr_issue) wr_pend <= 1'b0;
      // An edge that finds its buffer occupied is dropped.
      if (rd_rise && !rd_pend) begin
        rd_pend <= 1'b1;
        rd_buf  <= h_raddr;
      end
      if (wr_rise && !wr_pend) begin
        wr_pend <= 1'b1;
        wr_buf  <= h_waddr;
        wr_dbuf <= h_wdata;
      end
      if ((rd_rise && rd_pend) || (wr_rise && wr_pend))
        ovr_q <= 1'b1;
      if (rd_owner == OWN_HOST) h_rdata_q <= m_rdata;
      if (rd_owner == OWN_ENG)  e_rdata_q <= m_rdata;
    end
  end

  // Engine data is presented with its valid pulse, then held.
  assign e_rvalid  = (rd_owner == OWN_ENG);
  assign e_rdata   = e_rvalid ? m_rdata : e_rdata_q;
  assign h_rdata   = h_rdata_q;
  assign h_overrun = ovr_q;

endmodule

// File: tb/tb_gd_mem_arbiter.sv
// Directed bench for gd_mem_arbiter with a behavioural
// synchronous single-port RAM on the memory side.
module tb_gd_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        h_re = 1'b0;
  logic        h_we = 1'b0;
  logic [15:0] h_raddr = '0;
  logic [15:0] h_waddr = '0;
  logic [7:0]  h_wdata = '0;
  logic [7:0]  h_rdata;
  logic        h_overrun;
  logic        e_req = 1'b0;
  logic        e_we = 1'b0;
  logic [15:0] e_addr = '0;
  logic [7:0]  e_wdata = '0;
  logic        e_gnt;
  logic        e_rvalid;
  logic [7:0]  e_rdata;
  logic        m_en;
  logic        m_we;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata;
  logic [7:0]  m_rdata;

  logic        pl_en = 1'b0;
  logic [15:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;
  logic [7:0]  mem [0:65535];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gd_mem_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .h_re(h_re), .h_we(h_we),
    .h_raddr(h_raddr), .h_waddr(h_waddr),
    .h_wdata(h_wdata), .h_rdata(h_rdata),
    .h_overrun(h_overrun),
    .e_req(e_req), .e_we(e_we),
    .e_addr(e_addr), .e_wdata(e_wdata),
    .e_gnt(e_gnt), .e_rvalid(e_rvalid),
    .e_rdata(e_rdata),
    .m_en(m_en), .m_we(m_we),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (m_en) begin
      if (m_we) mem[m_addr] <= m_wdata;
      else m_rdata <= mem[m_addr];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic preload(input logic [15:0] a,
                         input logic [7:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en = 1'b1;
    step();
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    e_req = 1'b1;
    h_re = 1'b1;
    h_we = 1'b1;
    step();
    step();
    smp();
    n_cmp++;
    if ({m_en, m_we, e_gnt, e_rvalid, h_overrun} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_ctl got=%b want=00000",
               {m_en, m_we, e_gnt, e_rvalid, h_overrun});
    end
    n_cmp++;
    if ({h_rdata, e_rdata, m_addr, m_wdata} !== 40'h0) begin
      n_bad++;
      $display("FAIL reset_data got=%h want=0",
               {h_rdata, e_rdata, m_addr, m_wdata});
    end
    e_req = 1'b0;
    h_re = 1'b0;
    h_we = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_host_read();
    int n_acc;
    int at;
    n_acc = 0;
    at = -1;
    preload(16'h1234, 8'hA5);
    h_raddr = 16'h1234;
    h_re = 1'b1;
    for (int i = 0; i < 10; i++) begin
      smp();
      if (m_en && !m_we && m_addr == 16'h1234) begin
        n_acc++;
        at = i;
      end
      if (i == 2) begin
        n_cmp++;
        if (h_rdata !== 8'h00) begin
          n_bad++;
          $display("FAIL hrd_early got=%h want=00", h_rdata);
        end
      end
      if (i == 3) begin
        n_cmp++;
        if (h_rdata !== 8'hA5) begin
          n_bad++;
          $display("FAIL hrd_data got=%h want=a5", h_rdata);
        end
      end
      step();
    end
    h_re = 1'b0;
    n_cmp++;
    if (n_acc !== 1 || at !== 1) begin
      n_bad++;
      $display("FAIL hrd_once got=%0d@%0d want=1@1", n_acc, at);
    end
    step();
  endtask

  task automatic test_host_write();
    int n_acc;
    int at;
    n_acc = 0;
    at = -1;
    h_waddr = 16'h8010;
    h_wdata = 8'h3C;
    h_we = 1'b1;
    for (int i = 0; i < 6; i++) begin
      smp();
      if (m_en && m_we) begin
        n_acc++;
        if (m_addr == 16'h8010 && m_wdata == 8'h3C) at = i;
      end
      step();
    end
    h_we = 1'b0;
    n_cmp++;
    if (n_acc !== 1 || at !== 1) begin
      n_bad++;
      $display("FAIL hwr_once got=%0d@%0d want=1@1", n_acc, at);
    end
    n_cmp++;
    if (mem[16'h8010] !== 8'h3C) begin
      n_bad++;
      $display("FAIL hwr_mem got=%h want=3c", mem[16'h8010]);
    end
    h_raddr = 16'h8010;
    h_re = 1'b1;
    for (int i = 0; i < 5; i++) begin
      smp();
      if (i == 3) begin
        n_cmp++;
        if (h_rdata !== 8'h3C) begin
          n_bad++;
          $display("FAIL hwr_readback got=%h want=3c", h_rdata);
        end
      end
      step();
    end
    h_re = 1'b0;
    step();
  endtask

  task automatic test_contention();
    logic prev;
    logic want;
    prev = 1'b0;
    preload(16'h0100, 8'h5A);
    preload(16'h0200, 8'h77);
    e_addr = 16'h0100;
    e_we = 1'b0;
    e_req = 1'b1;
    for (int j = 0; j < 8; j++) begin
      if (j == 2) begin
        h_raddr = 16'h0200;
        h_re = 1'b1;
      end
      smp();
      want = (j != 3);
      n_cmp++;
      if (e_gnt !== want) begin
        n_bad++;
        $display("FAIL cont_gnt j=%0d got=%b want=%b",
                 j, e_gnt, want);
      end
      if (j == 3) begin
        n_cmp++;
        if (!(m_en && !m_we && m_addr == 16'h0200)) begin
          n_bad++;
          $display("FAIL cont_host got=%b%b/%h want=10/0200",
                   m_en, m_we, m_addr);
        end
      end
      n_cmp++;
      if (e_rvalid !== prev ||
          (prev && e_rdata !== 8'h5A)) begin
        n_bad++;
        $display("FAIL cont_rvalid j=%0d got=%b/%h want=%b/5a",
                 j, e_rvalid, e_rdata, prev);
      end
      if (j == 5) begin
        n_cmp++;
        if (h_rdata !== 8'h77) begin
          n_bad++;
          $display("FAIL cont_hrd got=%h want=77", h_rdata);
        end
      end
      prev = e_gnt;
      step();
    end
    e_req = 1'b0;
    h_re = 1'b0;
    step();
    step();
  endtask

  task automatic test_simultaneous();
    preload(16'h4444, 8'h11);
    h_waddr = 16'h4444;
    h_wdata = 8'hC3;
    h_raddr = 16'h4444;
    h_we = 1'b1;
    h_re = 1'b1;
    for (int i = 0; i < 6; i++) begin
      smp();
      if (i == 1) begin
        n_cmp++;
        if (!(m_en && m_we && m_addr == 16'h4444 &&
              m_wdata == 8'hC3)) begin
          n_bad++;
          $display("FAIL sim_wr got=%b%b/%h/%h want=11/4444/c3",
                   m_en, m_we, m_addr, m_wdata);
        end
      end
      if (i == 2) begin
        n_cmp++;
        if (!(m_en && !m_we && m_addr == 16'h4444)) begin
          n_bad++;
          $display("FAIL sim_rd got=%b%b/%h want=10/4444",
                   m_en, m_we, m_addr);
        end
      end
      if (i == 3) begin
        n_cmp++;
        if (h_rdata !== 8'h77) begin
          n_bad++;
          $display("FAIL sim_early got=%h want=77", h_rdata);
        end
      end
      if (i == 4) begin
        n_cmp++;
        if (h_rdata !== 8'hC3) begin
          n_bad++;
          $display("FAIL sim_data got=%h want=c3", h_rdata);
        end
      end
      step();
    end
    h_we = 1'b0;
    h_re = 1'b0;
    step();
  endtask

  task automatic test_overrun();
    int bad_acc;
    bad_acc = 0;
    preload(16'h5000, 8'h21);
    h_raddr = 16'h5000;
    h_re = 1'b1;
    smp();
    n_cmp++;
    if (h_overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL ovr_pre got=%b want=0", h_overrun);
    end
    step();
    force dut.rd_pend = 1'b1;
    h_re = 1'b0;
    smp();
    step();
    h_raddr = 16'h6000;
    h_re = 1'b1;
    smp();
    if (m_en && m_addr == 16'h6000) bad_acc++;
    step();
    release dut.rd_pend;
    for (int i = 0; i < 6; i++) begin
      smp();
      if (m_en && m_addr == 16'h6000) bad_acc++;
      if (i == 0 || i == 5) begin
        n_cmp++;
        if (h_overrun !== 1'b1) begin
          n_bad++;
          $display("FAIL ovr_flag i=%0d got=%b want=1",
                   i, h_overrun);
        end
      end
      if (i == 5) begin
        n_cmp++;
        if (m_en !== 1'b0 || h_rdata !== 8'h21) begin
          n_bad++;
          $display("FAIL ovr_idle got=%b/%h want=0/21",
                   m_en, h_rdata);
        end
      end
      step();
    end
    n_cmp++;
    if (bad_acc !== 0) begin
      n_bad++;
      $display("FAIL ovr_drop got=%0d want=0", bad_acc);
    end
    h_re = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_read();
    preload(16'h0300, 8'h9C);
    e_addr = 16'h0300;
    e_we = 1'b0;
    e_req = 1'b1;
    smp();
    n_cmp++;
    if (e_gnt !== 1'b1) begin
      n_bad++;
      $display("FAIL rmr_gnt got=%b want=1", e_gnt);
    end
    step();
    rst_n = 1'b0;
    e_req = 1'b0;
    smp();
    n_cmp++;
    if ({e_rvalid, e_gnt, m_en, m_we, h_overrun} !== 5'b0 ||
        {h_rdata, e_rdata, m_addr} !== 32'h0) begin
      n_bad++;
      $display("FAIL rmr_outs got=%b/%h want=0/0",
               {e_rvalid, e_gnt, m_en, m_we, h_overrun},
               {h_rdata, e_rdata, m_addr});
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    e_req = 1'b1;
    smp();
    n_cmp++;
    if (e_gnt !== 1'b1 || m_addr !== 16'h0300) begin
      n_bad++;
      $display("FAIL rmr_regnt got=%b/%h want=1/0300",
               e_gnt, m_addr);
    end
    step();
    e_req = 1'b0;
    smp();
    n_cmp++;
    if (e_rvalid !== 1'b1 || e_rdata !== 8'h9C) begin
      n_bad++;
      $display("FAIL rmr_rdata got=%b/%h want=1/9c",
               e_rvalid, e_rdata);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] want;
    e_we = 1'b1;
    e_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      e_addr = 16'h0700 + 16'(k);
      e_wdata = 8'h40 + 8'(k);
      smp();
      n_cmp++;
      if (e_gnt !== 1'b1 || m_we !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_wgnt k=%0d got=%b%b want=11",
                 k, e_gnt, m_we);
      end
      step();
    end
    e_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      e_req = (k < 3);
      e_addr = 16'h0700 + 16'(k);
      smp();
      if (k < 3) begin
        n_cmp++;
        if (e_gnt !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b_rgnt k=%0d got=%b want=1", k, e_gnt);
        end
      end
      if (k > 0) begin
        want = 8'h40 + 8'(k - 1);
        n_cmp++;
        if (e_rvalid !== 1'b1 || e_rdata !== want) begin
          n_bad++;
          $display("FAIL b2b_rdata k=%0d got=%b/%h want=1/%h",
                   k, e_rvalid, e_rdata, want);
        end
      end
      step();
    end
    e_req = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_host_read();
    test_host_write();
    test_contention();
    test_simultaneous();
    test_overrun();
    test_reset_mid_read();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
